mem_access_sequencer: RTL and testbench

- Multi-cycle MEM-stage access engine for the LC-3b pipeline. It takes the memory-related fields of the decoded control word and drives the cache port with a read/write handshake, then returns load data.
- Generalises single-level LDI/STI indirection to a parametrised pointer-chase depth.
- Generalises the fixed 16-bit high/low byte select (LDB/STB) to N byte lanes.
- Stalls the pipeline while an access is outstanding.

---
 rtl/mem_access_sequencer.sv | 153 +++++++++++++++
 tb/tb_mem_access_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_sequencer.sv
// MEM-stage access engine: sequences pointer-chase reads and a final word/byte
// load or store over a single-outstanding cache handshake, stalling upstream meanwhile.
module mem_access_sequencer #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int MAX_INDIRECT = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    input  logic                    req_read,
    input  logic                    req_write,
    input  logic                    req_byte,
    input  logic                    req_indirect,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    stall,
    output logic                    done,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_resp,
    output logic [1:0]              dbg_state
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int L  = $clog2(NB);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PTR  = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [2:0]            ptr_cnt_q, ptr_cnt_d;
    logic                  write_q, write_d;
    logic                  byte_q, byte_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  new_req;
    logic [L-1:0]          lane;
    logic [L+2:0]          lane_bit;
    logic [ADDR_WIDTH-1:0] aligned;
    logic [NB-1:0]         lane_onehot;
    logic [7:0]            lane_byte;

    assign new_req     = req_valid & (req_read | req_write);
    assign lane        = cur_addr_q[L-1:0];
    assign lane_bit    = {lane, 3'b000};
    assign aligned     = {cur_addr_q[ADDR_WIDTH-1:L], {L{1'b0}}};
    assign lane_onehot = {{(NB-1){1'b0}}, 1'b1} << lane;
    assign lane_byte   = mem_rdata[lane_bit +: 8];

    assign rdata     = rdata_q;
    assign dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cur_addr_q <= '0;
            ptr_cnt_q  <= '0;
            write_q    <= 1'b0;
            byte_q     <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            ptr_cnt_q  <= ptr_cnt_d;
            write_q    <= write_d;
            byte_q     <= byte_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
        end
    end

    // Handshake: mem_read/mem_write is a request held steady (with address, data and
    // enables) until the single-cycle mem_resp; the transfer completes on that edge.
    always_comb begin
        state_d         = state_q;
        cur_addr_d      = cur_addr_q;
        ptr_cnt_d       = ptr_cnt_q;
        write_d         = write_q;
        byte_d          = byte_q;
        wdata_d         = wdata_q;
        rdata_d         = rdata_q;
        stall           = 1'b0;
        done            = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = '1;
        mem_address     = aligned;
        mem_wdata       = '0;

        case (state_q)
            S_IDLE: begin
                if (new_req) begin
                    stall      = 1'b1;
                    cur_addr_d = req_addr;
                    ptr_cnt_d  = '0;
                    write_d    = req_write;
                    byte_d     = req_byte;
                    wdata_d    = req_wdata;
                    state_d    = req_indirect ? S_PTR : S_DATA;
                end
            end
            S_PTR: begin
                stall    = 1'b1;
                mem_read = 1'b1;
                if (mem_resp) begin
                    // Pointer is taken verbatim; its low bits pick the final byte lane.
                    cur_addr_d = ADDR_WIDTH'(mem_rdata);
                    ptr_cnt_d  = ptr_cnt_q + 3'd1;
                    if (ptr_cnt_q + 3'd1 == 3'(MAX_INDIRECT)) begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                stall = 1'b1;
                if (write_q) begin
                    mem_write = 1'b1;
                    if (byte_q) begin
                        mem_wdata       = {NB{wdata_q[7:0]}};
                        mem_byte_enable = lane_onehot;
                    end else begin
                        mem_wdata = wdata_q;
                    end
                end else begin
                    mem_read = 1'b1;
                end
                if (mem_resp) begin
                    if (!write_q) begin
                        rdata_d = byte_q ? {{(DATA_WIDTH-8){1'b0}}, lane_byte} : mem_rdata;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer: three configurations (16b/1 hop, 16b/2 hops,
// 32b/1 hop) share one driver, one cache model and one scoreboard via a select index.
module tb_mem_access_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_read = 1'b0, req_write = 1'b0;
    logic        req_byte = 1'b0, req_indirect = 1'b0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] mem_rdata = '0;
    logic        mem_resp = 1'b0;
    int          sel = 0;
    int          resp_delay = 0;
    int          wait_cnt = 0;

    logic        stall_w[3], done_w[3], mr_w[3], mw_w[3];
    logic [15:0] addr_w[3];
    logic [1:0]  st_w[3];
    logic [1:0]  be16[2];
    logic [15:0] wd16[2], rd16[2];
    logic [3:0]  be32;
    logic [31:0] wd32, rd32;

    logic        m_stall, m_done, m_rd, m_wr;
    logic [3:0]  m_be;
    logic [15:0] m_addr;
    logic [31:0] m_wd, m_rdata;
    logic [1:0]  m_state;

    logic [63:0] exp_q[$];
    logic [32:0] exp_rd_q[$];
    logic [31:0] mem_model[int];
    int          n_checks = 0;
    int          n_errs = 0;

    always #5 clk = ~clk;

    mem_access_sequencer #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .MAX_INDIRECT(1)) u_w16_i1 (
        .clk(clk), .reset(reset), .req_valid(req_valid && sel == 0), .req_read(req_read),
        .req_write(req_write), .req_byte(req_byte), .req_indirect(req_indirect),
        .req_addr(req_addr), .req_wdata(req_wdata[15:0]), .stall(stall_w[0]), .done(done_w[0]),
        .rdata(rd16[0]), .mem_read(mr_w[0]), .mem_write(mw_w[0]), .mem_byte_enable(be16[0]),
        .mem_address(addr_w[0]), .mem_wdata(wd16[0]), .mem_rdata(mem_rdata[15:0]),
        .mem_resp(mem_resp && sel == 0), .dbg_state(st_w[0]));

    mem_access_sequencer #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .MAX_INDIRECT(2)) u_w16_i2 (
        .clk(clk), .reset(reset), .req_valid(req_valid && sel == 1), .req_read(req_read),
        .req_write(req_write), .req_byte(req_byte), .req_indirect(req_indirect),
        .req_addr(req_addr), .req_wdata(req_wdata[15:0]), .stall(stall_w[1]), .done(done_w[1]),
        .rdata(rd16[1]), .mem_read(mr_w[1]), .mem_write(mw_w[1]), .mem_byte_enable(be16[1]),
        .mem_address(addr_w[1]), .mem_wdata(wd16[1]), .mem_rdata(mem_rdata[15:0]),
        .mem_resp(mem_resp && sel == 1), .dbg_state(st_w[1]));

    mem_access_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MAX_INDIRECT(1)) u_w32_i1 (
        .clk(clk), .reset(reset), .req_valid(req_valid && sel == 2), .req_read(req_read),
        .req_write(req_write), .req_byte(req_byte), .req_indirect(req_indirect),
        .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall_w[2]), .done(done_w[2]),
        .rdata(rd32), .mem_read(mr_w[2]), .mem_write(mw_w[2]), .mem_byte_enable(be32),
        .mem_address(addr_w[2]), .mem_wdata(wd32), .mem_rdata(mem_rdata),
        .mem_resp(mem_resp && sel == 2), .dbg_state(st_w[2]));

    always_comb begin
        m_stall = 1'b0; m_done = 1'b0; m_rd = 1'b0; m_wr = 1'b0;
        m_be = '0; m_addr = '0; m_wd = '0; m_rdata = '0; m_state = '0;
        case (sel)
            0, 1: begin
                m_stall = stall_w[sel]; m_done = done_w[sel]; m_rd = mr_w[sel];
                m_wr = mw_w[sel]; m_addr = addr_w[sel]; m_state = st_w[sel];
                m_be = {2'b00, be16[sel]}; m_wd = {16'h0, wd16[sel]};
                m_rdata = {16'h0, rd16[sel]};
            end
            default: begin
                m_stall = stall_w[2]; m_done = done_w[2]; m_rd = mr_w[2];
                m_wr = mw_w[2]; m_addr = addr_w[2]; m_state = st_w[2];
                m_be = be32; m_wd = wd32; m_rdata = rd32;
            end
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t sel=%0d)", name, act, exp, $time, sel);
        end
    endtask

    function automatic logic [63:0] rec(input logic wr, input logic [3:0] be,
                                        input logic [15:0] a, input logic [31:0] wd);
        return {11'b0, wr, be, a, wd};
    endfunction

    // Cache model plus scoreboard monitor; both act on the falling edge.
    always @(negedge clk) begin
        mem_resp = 1'b0;
        if (m_rd || m_wr) begin
            chk("rd_wr_exclusive", {63'b0, m_rd & m_wr}, 64'd0);
            if (wait_cnt >= resp_delay) begin
                mem_resp = 1'b1;
                wait_cnt = 0;
                if (m_rd) mem_rdata = mem_model.exists(int'(m_addr)) ? mem_model[int'(m_addr)] : 32'h0;
                chk("access_expected", {63'b0, exp_q.size() != 0}, 64'd1);
                if (exp_q.size() != 0) chk("mem_access", rec(m_wr, m_be, m_addr, m_wd), exp_q.pop_front());
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
        if (m_done) begin
            chk("done_expected", {63'b0, exp_rd_q.size() != 0}, 64'd1);
            if (exp_rd_q.size() != 0) begin
                logic [32:0] e;
                e = exp_rd_q.pop_front();
                if (e[32]) chk("rdata", {32'h0, m_rdata}, {32'h0, e[31:0]});
            end
        end
    end

    task automatic access(input int s, input logic rd, input logic wr, input logic by,
                          input logic ind, input logic [15:0] addr, input logic [31:0] wd,
                          input int dly, input int n_hs);
        int  stall_cnt;
        bit  got;
        stall_cnt = 0;
        got = 0;
        @(posedge clk); #1;
        sel = s; resp_delay = dly;
        req_read = rd; req_write = wr; req_byte = by; req_indirect = ind;
        req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (m_stall) stall_cnt++;
            if (m_done) got = 1;
            @(posedge clk); #1;
            // Latched copies must be used: scramble the request fields after acceptance.
            req_valid = 1'b0;
            req_addr = 16'($urandom_range(0, 16'hFFFF));
            req_wdata = $urandom;
            req_byte = 1'($urandom_range(0, 1));
            req_indirect = 1'($urandom_range(0, 1));
        end
        chk("done_seen", {63'b0, got}, 64'd1);
        chk("stall_cycles", 64'(stall_cnt), 64'(1 + n_hs * (dly + 1)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk("rst_state", {62'b0, m_state}, 64'd0);
            chk("rst_stall_done", {62'b0, m_stall, m_done}, 64'd0);
            chk("rst_rd_wr", {62'b0, m_rd, m_wr}, 64'd0);
            chk("rst_rdata", {32'h0, m_rdata}, 64'd0);
            chk("rst_addr_wdata", {m_addr, m_wd}, 64'd0);
            chk("rst_byte_en", {60'b0, m_be}, (s == 2) ? 64'hF : 64'h3);
        end

        // Word load, 16-bit: misaligned address, response after 3 wait cycles.
        mem_model[16'h3004] = 32'hBEEF;
        exp_q.push_back(rec(1'b0, 4'h3, 16'h3004, 32'h0));
        exp_rd_q.push_back({1'b1, 32'hBEEF});
        access(0, 1, 0, 0, 0, 16'h3005, 32'h0, 3, 1);

        // Byte stores, upper then lower lane.
        exp_q.push_back(rec(1'b1, 4'b0010, 16'h2000, 32'hABAB));
        exp_rd_q.push_back({1'b0, 32'h0});
        access(0, 0, 1, 1, 0, 16'h2001, 32'h12AB, 1, 1);
        exp_q.push_back(rec(1'b1, 4'b0001, 16'h2000, 32'hABAB));
        exp_rd_q.push_back({1'b0, 32'h0});
        access(0, 0, 1, 1, 0, 16'h2000, 32'h12AB, 0, 1);

        // Read and write together resolve as a write.
        exp_q.push_back(rec(1'b1, 4'h3, 16'h1234, 32'h5A5A));
        exp_rd_q.push_back({1'b0, 32'h0});
        access(0, 1, 1, 0, 0, 16'h1234, 32'h5A5A, 0, 1);

        // 32-bit byte load of lane 3, then byte store to lane 2.
        mem_model[16'h0100] = 32'h11223344;
        exp_q.push_back(rec(1'b0, 4'hF, 16'h0100, 32'h0));
        exp_rd_q.push_back({1'b1, 32'h00000011});
        access(2, 1, 0, 1, 0, 16'h0103, 32'h0, 2, 1);
        exp_q.push_back(rec(1'b1, 4'b0100, 16'h0100, 32'hCDCDCDCD));
        exp_rd_q.push_back({1'b0, 32'h0});
        access(2, 0, 1, 1, 0, 16'h0102, 32'h000000CD, 0, 1);

        // LDI with one pointer hop.
        mem_model[16'h4000] = 32'h5000;
        mem_model[16'h5000] = 32'h0042;
        exp_q.push_back(rec(1'b0, 4'h3, 16'h4000, 32'h0));
        exp_q.push_back(rec(1'b0, 4'h3, 16'h5000, 32'h0));
        exp_rd_q.push_back({1'b1, 32'h0042});
        access(0, 1, 0, 0, 1, 16'h4000, 32'h0, 0, 2);

        // Indirect store through a two-hop chain.
        mem_model[16'h4000] = 32'h6000;
        mem_model[16'h6000] = 32'h7002;
        exp_q.push_back(rec(1'b0, 4'h3, 16'h4000, 32'h0));
        exp_q.push_back(rec(1'b0, 4'h3, 16'h6000, 32'h0));
        exp_q.push_back(rec(1'b1, 4'h3, 16'h7002, 32'h9999));
        exp_rd_q.push_back({1'b0, 32'h0});
        access(1, 0, 1, 0, 1, 16'h4000, 32'h9999, 1, 3);

        // Indirect byte load: odd pointer selects the upper lane.
        mem_model[16'h4000] = 32'h5003;
        mem_model[16'h5002] = 32'hA1B2;
        exp_q.push_back(rec(1'b0, 4'h3, 16'h4000, 32'h0));
        exp_q.push_back(rec(1'b0, 4'h3, 16'h5002, 32'h0));
        exp_rd_q.push_back({1'b1, 32'h00A1});
        access(0, 1, 0, 1, 1, 16'h4000, 32'h0, 1, 2);

        // Reset mid-DATA while the response arrives in the same cycle.
        mem_model[16'h3000] = 32'h1357;
        exp_q.push_back(rec(1'b0, 4'h3, 16'h3000, 32'h0));
        @(posedge clk); #1;
        sel = 0; resp_delay = 0;
        req_read = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_indirect = 1'b0;
        req_addr = 16'h3000; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_state", {62'b0, m_state}, 64'd0);
        chk("abort_rd_wr", {62'b0, m_rd, m_wr}, 64'd0);
        chk("abort_rdata", {32'h0, m_rdata}, 64'd0);
        chk("abort_done_stall", {62'b0, m_done, m_stall}, 64'd0);
        chk("abort_addr", {48'h0, m_addr}, 64'd0);
        repeat (3) @(negedge clk);

        // Normal access after the abort.
        exp_q.push_back(rec(1'b0, 4'h3, 16'h3004, 32'h0));
        exp_rd_q.push_back({1'b1, 32'hBEEF});
        access(0, 1, 0, 0, 0, 16'h3005, 32'h0, 2, 1);

        repeat (4) @(negedge clk);
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        chk("exp_rd_q_drained", 64'(exp_rd_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
        $finish;
    end
endmodule
